steel_mtimer: RTL and testbench



---
 rtl/steel_mtimer_pkg.sv | 20 ++
 rtl/steel_mtimer_byte_mask_merge.sv | 19 +
 rtl/steel_mtimer.sv | 131 +++++++++++++
 tb/tb_steel_mtimer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/steel_mtimer_pkg.sv
// Shared constants for the steel_mtimer machine timer: register offsets,
// reset values and the word-index helper used by the address decoder.
package steel_mtimer_pkg;

  localparam logic [4:0]  MTIME_LO_OFS    = 5'h00;
  localparam logic [4:0]  MTIME_HI_OFS    = 5'h04;
  localparam logic [4:0]  MTIMECMP_LO_OFS = 5'h08;
  localparam logic [4:0]  MTIMECMP_HI_OFS = 5'h0C;
  localparam logic [4:0]  MTIMER_CTRL_OFS = 5'h10;

  localparam logic [63:0] MTIME_RESET     = 64'h0;
  localparam logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic        EN_RESET        = 1'b1;

  // The window is word-addressed; the low two offset bits never take part.
  function automatic logic [2:0] word_of(input logic [4:0] ofs);
    return ofs[4:2];
  endfunction

endpackage

// File: rtl/steel_mtimer_byte_mask_merge.sv
// Byte-granular merge of store data into a 32-bit register half:
// bytes with their mask bit set come from i_new, the rest from i_old.
module byte_mask_merge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_merged
);

  always_comb begin
    // NOTE: a full default before the conditional overrides keeps this purely
    // combinational; without it, unmasked bytes would infer latches.
    o_merged = i_old;
    for (int i = 0; i < 4; i++) begin
      if (i_mask[i]) o_merged[8*i +: 8] = i_new[8*i +: 8];
    end
  end

endmodule

// File: rtl/steel_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on the data bus, a CLK_DIV
// prescaler gated by CTRL.EN, a registered level interrupt and read mux.
module steel_mtimer
  import steel_mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          CLK_DIV   = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDR,
  input  logic [31:0] WR_DATA,
  input  logic        WR_REQ,
  input  logic [3:0]  WR_MASK,
  output logic [31:0] RD_DATA,
  output logic [63:0] REAL_TIME,
  output logic        T_IRQ
);

  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_en;
  logic [15:0] r_presc;
  logic [31:0] r_rd_data;
  logic        r_irq;

  logic        w_sel;
  logic [2:0]  w_word;
  logic        w_wr;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_ctrl;
  logic        w_tick;
  logic [31:0] w_mtime_lo_merged;
  logic [31:0] w_mtime_hi_merged;
  logic [31:0] w_cmp_lo_merged;
  logic [31:0] w_cmp_hi_merged;
  logic [63:0] w_mtime_next;
  logic [63:0] w_mtimecmp_next;
  logic        w_en_next;
  logic [15:0] w_presc_next;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_sel    = (ADDR[31:5] == BASE_ADDR[31:5]);
  assign w_word   = ADDR[4:2];
  assign w_unused = ^ADDR[1:0];
  assign w_wr     = w_sel && WR_REQ;

  assign w_wr_mtime_lo = w_wr && (w_word == word_of(MTIME_LO_OFS));
  assign w_wr_mtime_hi = w_wr && (w_word == word_of(MTIME_HI_OFS));
  assign w_wr_cmp_lo   = w_wr && (w_word == word_of(MTIMECMP_LO_OFS));
  assign w_wr_cmp_hi   = w_wr && (w_word == word_of(MTIMECMP_HI_OFS));
  assign w_wr_ctrl     = w_wr && (w_word == word_of(MTIMER_CTRL_OFS));

  byte_mask_merge u_merge_mtime_lo (
    .i_old(r_mtime[31:0]),     .i_new(WR_DATA), .i_mask(WR_MASK), .o_merged(w_mtime_lo_merged)
  );
  byte_mask_merge u_merge_mtime_hi (
    .i_old(r_mtime[63:32]),    .i_new(WR_DATA), .i_mask(WR_MASK), .o_merged(w_mtime_hi_merged)
  );
  byte_mask_merge u_merge_cmp_lo (
    .i_old(r_mtimecmp[31:0]),  .i_new(WR_DATA), .i_mask(WR_MASK), .o_merged(w_cmp_lo_merged)
  );
  byte_mask_merge u_merge_cmp_hi (
    .i_old(r_mtimecmp[63:32]), .i_new(WR_DATA), .i_mask(WR_MASK), .o_merged(w_cmp_hi_merged)
  );

  // Prescaler advances only while enabled; the tick is its terminal count.
  assign w_tick       = r_en && (r_presc == PRESC_MAX);
  assign w_presc_next = !r_en ? r_presc : (w_tick ? 16'h0 : r_presc + 16'h1);

  assign w_en_next = (w_wr_ctrl && WR_MASK[0]) ? WR_DATA[0] : r_en;

  // A software write to either mtime half swallows a coincident tick.
  always_comb begin
    w_mtime_next = r_mtime;
    if (w_wr_mtime_lo)      w_mtime_next = {r_mtime[63:32], w_mtime_lo_merged};
    else if (w_wr_mtime_hi) w_mtime_next = {w_mtime_hi_merged, r_mtime[31:0]};
    else if (w_tick)        w_mtime_next = r_mtime + 64'h1;
  end

  always_comb begin
    w_mtimecmp_next = r_mtimecmp;
    if (w_wr_cmp_lo)      w_mtimecmp_next = {r_mtimecmp[63:32], w_cmp_lo_merged};
    else if (w_wr_cmp_hi) w_mtimecmp_next = {w_cmp_hi_merged, r_mtimecmp[31:0]};
  end

  always_comb begin
    w_rd_data = 32'h0;
    if (w_sel) begin
      case (w_word)
        word_of(MTIME_LO_OFS):    w_rd_data = r_mtime[31:0];
        word_of(MTIME_HI_OFS):    w_rd_data = r_mtime[63:32];
        word_of(MTIMECMP_LO_OFS): w_rd_data = r_mtimecmp[31:0];
        word_of(MTIMECMP_HI_OFS): w_rd_data = r_mtimecmp[63:32];
        word_of(MTIMER_CTRL_OFS): w_rd_data = {31'h0, r_en};
        default:                  w_rd_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge state, independent of statement order.
    if (RESET) begin
      r_mtime    <= MTIME_RESET;
      r_mtimecmp <= MTIMECMP_RESET;
      r_en       <= EN_RESET;
      r_presc    <= 16'h0;
      r_rd_data  <= 32'h0;
      r_irq      <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_next;
      r_mtimecmp <= w_mtimecmp_next;
      r_en       <= w_en_next;
      r_presc    <= w_presc_next;
      r_rd_data  <= w_rd_data;
      r_irq      <= (w_mtime_next >= w_mtimecmp_next);
    end
  end

  assign RD_DATA   = r_rd_data;
  assign REAL_TIME = r_mtime;
  assign T_IRQ     = r_irq;

endmodule

// File: tb/tb_steel_mtimer.sv
// Directed bench for steel_mtimer: one instance with CLK_DIV=1 and one with
// CLK_DIV=4 share the bus; expected values are worked out by hand below.
module tb_steel_mtimer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        wr_req;
  logic [3:0]  wr_mask;

  logic [31:0] rd1, rd4;
  logic [63:0] rt1, rt4;
  logic        irq1, irq4;

  int total = 0;
  int bad   = 0;

  steel_mtimer #(.BASE_ADDR(BASE), .CLK_DIV(1)) u_dut (
    .CLK(clk), .RESET(rst), .ADDR(addr), .WR_DATA(wr_data), .WR_REQ(wr_req),
    .WR_MASK(wr_mask), .RD_DATA(rd1), .REAL_TIME(rt1), .T_IRQ(irq1)
  );

  steel_mtimer #(.BASE_ADDR(BASE), .CLK_DIV(4)) u_dut4 (
    .CLK(clk), .RESET(rst), .ADDR(addr), .WR_DATA(wr_data), .WR_REQ(wr_req),
    .WR_MASK(wr_mask), .RD_DATA(rd4), .REAL_TIME(rt4), .T_IRQ(irq4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [4:0] ofs, input logic [31:0] data, input logic [3:0] mask);
    addr    = BASE | 32'(ofs);
    wr_data = data;
    wr_mask = mask;
    wr_req  = 1'b1;
  endtask

  task automatic bus_idle();
    addr    = 32'h0;
    wr_data = 32'h0;
    wr_mask = 4'h0;
    wr_req  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    cyc();
    check("rst_time", rt1, 64'h0);
    check("rst_irq", {63'h0, irq1}, 64'h0);
    check("rst_rd", {32'h0, rd1}, 64'h0);
    rst = 1'b0;

    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("count", rt1, 64'(i));
    end

    addr = BASE + 32'h8;
    cyc();
    check("rd_cmp_lo_rst", {32'h0, rd1}, 64'hFFFF_FFFF);
    check("count4", rt1, 64'd4);

    // Compare threshold of 20: mtime is 5 and 6 after these two writes.
    bus_wr(5'h0C, 32'h0, 4'hF);
    cyc();
    check("irq_cmp_hi0", {63'h0, irq1}, 64'h0);
    bus_wr(5'h08, 32'd20, 4'hF);
    cyc();
    check("irq_cmp_lo20", {63'h0, irq1}, 64'h0);
    bus_idle();
    repeat (13) cyc();
    check("time19", rt1, 64'd19);
    check("irq_at19", {63'h0, irq1}, 64'h0);
    cyc();
    check("time20", rt1, 64'd20);
    check("irq_at20", {63'h0, irq1}, 64'h1);
    cyc();
    check("irq_at21", {63'h0, irq1}, 64'h1);
    bus_wr(5'h0C, 32'h1, 4'hF);
    cyc();
    check("irq_drop", {63'h0, irq1}, 64'h0);
    check("time22", rt1, 64'd22);

    // Wrap: the mtime writes replace the tick in their cycles.
    bus_wr(5'h00, 32'hFFFF_FFFF, 4'hF);
    cyc();
    check("wr_mtime_lo", rt1, 64'h0000_0000_FFFF_FFFF);
    check("irq_lo_ones", {63'h0, irq1}, 64'h0);
    bus_wr(5'h04, 32'hFFFF_FFFF, 4'hF);
    cyc();
    check("wr_mtime_hi", rt1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("irq_all_ones", {63'h0, irq1}, 64'h1);
    bus_idle();
    cyc();
    check("wrap_zero", rt1, 64'h0);
    check("irq_wrap", {63'h0, irq1}, 64'h0);

    // Byte-masked store into MTIMECMP_LO.
    bus_wr(5'h08, 32'h0, 4'hF);
    cyc();
    bus_wr(5'h08, 32'hAABB_CCDD, 4'b0101);
    cyc();
    check("rd_prewrite", {32'h0, rd1}, 64'h0);
    bus_wr(5'h08, 32'hFFFF_FFFF, 4'h0);
    cyc();
    check("rd_masked", {32'h0, rd1}, 64'h00BB_00DD);
    bus_idle();
    addr = BASE + 32'h8;
    cyc();
    check("mask0_noop", {32'h0, rd1}, 64'h00BB_00DD);
    addr = BASE + 32'h20;
    cyc();
    check("rd_unselected", {32'h0, rd1}, 64'h0);
    addr = BASE + 32'h14;
    cyc();
    check("rd_unmapped", {32'h0, rd1}, 64'h0);
    addr = BASE + 32'h10;
    cyc();
    check("rd_ctrl", {32'h0, rd1}, 64'h1);

    // Prescaler: fresh reset, then disable, hold, re-enable.
    rst = 1'b1;
    bus_idle();
    cyc();
    check("div4_rst", rt4, 64'h0);
    rst = 1'b0;
    bus_wr(5'h10, 32'h0, 4'hF);
    cyc();
    bus_idle();
    check("div1_last_tick", rt1, 64'd1);
    check("div4_no_tick", rt4, 64'h0);
    repeat (10) cyc();
    check("div4_frozen", rt4, 64'h0);
    check("div1_frozen", rt1, 64'd1);
    bus_wr(5'h10, 32'h1, 4'hF);
    cyc();
    bus_idle();
    check("div4_reenable", rt4, 64'h0);
    cyc();
    cyc();
    check("div4_pre_tick", rt4, 64'h0);
    check("div1_running", rt1, 64'd3);
    cyc();
    check("div4_tick1", rt4, 64'd1);
    repeat (3) cyc();
    check("div4_hold1", rt4, 64'd1);
    cyc();
    check("div4_tick2", rt4, 64'd2);

    // Reset overrides a concurrent mtime write.
    bus_wr(5'h00, 32'h1234_5678, 4'hF);
    rst = 1'b1;
    cyc();
    check("rstwr_time", rt1, 64'h0);
    check("rstwr_rd", {32'h0, rd1}, 64'h0);
    check("rstwr_irq", {63'h0, irq1}, 64'h0);
    rst = 1'b0;
    bus_idle();
    addr = BASE + 32'h8;
    cyc();
    check("rstwr_cmp", {32'h0, rd1}, 64'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
